// File: rtl/spi_flash_responder_if.sv
// Word-wide read port between the SPI flash responder and its backing memory.
// The responder holds rom_valid/rom_addr until rom_ready; same-cycle ready is legal.
interface spi_flash_responder_if;
    logic        rom_valid;
    logic        rom_ready;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;

    modport master (
        output rom_valid,
        output rom_addr,
        input  rom_ready,
        input  rom_rdata
    );

    modport slave (
        input  rom_valid,
        input  rom_addr,
        output rom_ready,
        output rom_rdata
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Read-only serial NOR flash emulator: decodes SPI mode-0 commands, fetches words from a
// backing memory and shifts bytes out on MISO. SPI pins are oversampled by clk.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS   = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   spi_csb,
    input  logic                   spi_clk,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    spi_flash_responder_if.master  rom,
    output logic                   underrun,
    output logic                   powered_down
);
    localparam int unsigned WordBits = ADDR_BITS - 2;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StIgnore} state_e;

    logic [SYNC_STAGES-1:0] csb_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   csb_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
        end
    end

    state_e                state_q;
    logic [4:0]            bit_cnt_q;
    logic [22:0]           shift_in_q;
    logic                  dummy_q;
    logic                  pd_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [WordBits-1:0]   buf_waddr_q;
    logic [31:0]           buf_word_q;
    logic                  buf_want_q;
    logic                  buf_valid_q;
    logic [7:0]            sh_data_q;
    logic                  sh_full_q;
    logic                  rom_valid_q;
    logic [WordBits-1:0]   rom_waddr_q;
    logic                  miso_q;
    logic                  oe_q;
    logic                  underrun_q;

    logic [7:0]  cmd_byte;
    logic [23:0] cmd_addr;
    logic        rom_done;
    logic        data_fall;
    logic        load_sh;
    logic [7:0]  buf_byte;

    assign cmd_byte  = {shift_in_q[6:0], mosi_s};
    assign cmd_addr  = {shift_in_q, mosi_s};
    assign rom_done  = rom_valid_q & rom.rom_ready;
    assign data_fall = (state_q == StData) & sclk_fall;
    // Loading is held off on a shift edge so a late byte never lands against a stale address.
    assign load_sh   = buf_want_q & buf_valid_q & ~sh_full_q & ~data_fall &
                       (buf_waddr_q == addr_q[ADDR_BITS-1:2]);

    always_comb begin
        buf_byte = buf_word_q[7:0];
        unique case (addr_q[1:0])
            2'd0: buf_byte = buf_word_q[7:0];
            2'd1: buf_byte = buf_word_q[15:8];
            2'd2: buf_byte = buf_word_q[23:16];
            2'd3: buf_byte = buf_word_q[31:24];
            default: buf_byte = buf_word_q[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            dummy_q     <= 1'b0;
            pd_q        <= 1'b0;
            addr_q      <= '0;
            buf_waddr_q <= '0;
            buf_word_q  <= '0;
            buf_want_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            sh_data_q   <= '0;
            sh_full_q   <= 1'b0;
            rom_valid_q <= 1'b0;
            rom_waddr_q <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            // Responses are accepted only for the word the buffer is currently waiting on.
            if (rom_done) begin
                rom_valid_q <= 1'b0;
                if (buf_want_q && !buf_valid_q && rom_waddr_q == buf_waddr_q) begin
                    buf_word_q  <= rom.rom_rdata;
                    buf_valid_q <= 1'b1;
                end
            end else if (!rom_valid_q && buf_want_q && !buf_valid_q) begin
                rom_valid_q <= 1'b1;
                rom_waddr_q <= buf_waddr_q;
            end

            if (load_sh) begin
                sh_data_q <= buf_byte;
                sh_full_q <= 1'b1;
                if (addr_q[1:0] == 2'd3) begin
                    buf_valid_q <= 1'b0;
                    buf_waddr_q <= buf_waddr_q + WordBits'(1);
                    if (!rom_valid_q) begin
                        rom_valid_q <= 1'b1;
                        rom_waddr_q <= buf_waddr_q + WordBits'(1);
                    end
                end
            end

            unique case (state_q)
                StIdle: begin
                    state_q   <= StCmd;
                    bit_cnt_q <= '0;
                end
                StCmd: begin
                    if (sclk_rise) begin
                        shift_in_q <= {shift_in_q[21:0], mosi_s};
                        bit_cnt_q  <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            state_q   <= StIgnore;
                            if (cmd_byte == 8'hAB) begin
                                pd_q <= 1'b0;
                            end else if (!pd_q) begin
                                if (cmd_byte == 8'hB9) begin
                                    pd_q <= 1'b1;
                                end else if (cmd_byte == 8'h03 || cmd_byte == 8'h0B) begin
                                    state_q <= StAddr;
                                    dummy_q <= (cmd_byte == 8'h0B);
                                end
                            end
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        shift_in_q <= {shift_in_q[21:0], mosi_s};
                        bit_cnt_q  <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q   <= '0;
                            addr_q      <= cmd_addr[ADDR_BITS-1:0];
                            buf_want_q  <= 1'b1;
                            buf_valid_q <= 1'b0;
                            sh_full_q   <= 1'b0;
                            buf_waddr_q <= cmd_addr[ADDR_BITS-1:2];
                            if (!rom_valid_q) begin
                                rom_valid_q <= 1'b1;
                                rom_waddr_q <= cmd_addr[ADDR_BITS-1:2];
                            end
                            state_q <= dummy_q ? StDummy : StData;
                            oe_q    <= !dummy_q;
                        end
                    end
                end
                StDummy: begin
                    if (sclk_rise) begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            state_q   <= StData;
                            oe_q      <= 1'b1;
                        end
                    end
                end
                StData: begin
                    if (sclk_fall) begin
                        if (sh_full_q) begin
                            miso_q <= sh_data_q[3'd7 - bit_cnt_q[2:0]];
                        end else begin
                            miso_q     <= 1'b0;
                            underrun_q <= 1'b1;
                        end
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            bit_cnt_q <= '0;
                            addr_q    <= addr_q + ADDR_BITS'(1);
                            sh_full_q <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                StIgnore: ;
                default: state_q <= StIdle;
            endcase

            // Deselect wins; an in-flight fetch still completes but its data is dropped.
            if (csb_s) begin
                state_q     <= StIdle;
                bit_cnt_q   <= '0;
                oe_q        <= 1'b0;
                miso_q      <= 1'b0;
                buf_want_q  <= 1'b0;
                buf_valid_q <= 1'b0;
                sh_full_q   <= 1'b0;
            end
        end
    end

    assign spi_miso      = miso_q;
    assign spi_miso_oe   = oe_q;
    assign underrun      = underrun_q;
    assign powered_down  = pd_q;
    assign rom.rom_valid = rom_valid_q;
    assign rom.rom_addr  = {{(32 - ADDR_BITS){1'b0}}, rom_waddr_q, 2'b00};
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed SPI transactions with expected MISO bytes and
// memory fetch addresses queued up front and checked by independent monitors.
module tb_spi_flash_responder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic spi_csb = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, underrun, powered_down;

    spi_flash_responder_if rom_if();

    spi_flash_responder dut (
        .clk          (clk),
        .resetn       (resetn),
        .spi_csb      (spi_csb),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .rom          (rom_if),
        .underrun     (underrun),
        .powered_down (powered_down)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int latency = 0;
    int wait_cnt = 0;
    int valid_seen = 0;
    int oe_seen = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_addrs[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hDDCC_BBAA;
            32'h0000_0004: return 32'h4433_2211;
            32'h0000_0008: return 32'h8877_6655;
            32'h00FF_FFFC: return 32'h0F0E_0D0C;
            default:       return 32'h5A5A_5A5A;
        endcase
    endfunction

    assign rom_if.rom_rdata = rom_word(rom_if.rom_addr);
    assign rom_if.rom_ready = rom_if.rom_valid && (wait_cnt >= latency);

    always @(posedge clk) begin
        if (rom_if.rom_valid && !rom_if.rom_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory-side monitor: every completed fetch must match the next expected address.
    always @(negedge clk) begin
        if (rom_if.rom_valid) valid_seen++;
        if (spi_miso_oe) oe_seen++;
        if (resetn && rom_if.rom_valid && rom_if.rom_ready) begin
            if (exp_addrs.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rom_addr: got unexpected fetch 0x%0h", rom_if.rom_addr);
            end else begin
                check("rom_addr", rom_if.rom_addr, exp_addrs.pop_front());
            end
        end
    end

    // Master-side monitor: assembles MISO bytes sampled on rising spi_clk while driven.
    logic [7:0] mon_sh = '0;
    int mon_cnt = 0;
    always @(posedge spi_clk or posedge spi_csb) begin
        if (spi_csb) begin
            mon_cnt = 0;
        end else if (spi_miso_oe) begin
            mon_sh = {mon_sh[6:0], spi_miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_bytes.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL miso_byte: got unexpected byte 0x%0h", mon_sh);
                end else begin
                    check("miso_byte", {24'h0, mon_sh}, {24'h0, exp_bytes.pop_front()});
                end
            end
        end
    end

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic spi_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
        spi_csb = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(cmd);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    task automatic spi_stop();
        repeat (2) @(negedge clk);
        spi_csb = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    int v0, o0;

    initial begin
        repeat (4) @(negedge clk);
        check("reset_miso", {31'h0, spi_miso}, 32'h0);
        check("reset_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("reset_rom_valid", {31'h0, rom_if.rom_valid}, 32'h0);
        check("reset_rom_addr", rom_if.rom_addr, 32'h0);
        check("reset_underrun", {31'h0, underrun}, 32'h0);
        check("reset_powered_down", {31'h0, powered_down}, 32'h0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // READ at 0x000004, four bytes, prefetch of the following word
        exp_addrs.push_back(32'h4);
        exp_addrs.push_back(32'h8);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        spi_csb = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h03);
        check("oe_in_addr", {31'h0, spi_miso_oe}, 32'h0);
        spi_byte(8'h00);
        spi_byte(8'h00);
        spi_byte(8'h04);
        spi_byte(8'h00);
        check("oe_in_data", {31'h0, spi_miso_oe}, 32'h1);
        for (int i = 0; i < 3; i++) spi_byte(8'h00);
        spi_stop();
        check("oe_after_csb", {31'h0, spi_miso_oe}, 32'h0);

        // FAST READ at 0x000002 with dummy byte, crossing into the next word
        exp_addrs.push_back(32'h0);
        exp_addrs.push_back(32'h4);
        exp_bytes.push_back(8'hCC);
        exp_bytes.push_back(8'hDD);
        exp_bytes.push_back(8'h11);
        spi_cmd_addr(8'h0B, 24'h000002);
        check("oe_in_dummy", {31'h0, spi_miso_oe}, 32'h0);
        spi_byte(8'h00);
        for (int i = 0; i < 3; i++) spi_byte(8'h00);
        spi_stop();

        // READ at the top of the address space wraps to zero
        exp_addrs.push_back(32'h00FF_FFFC);
        exp_addrs.push_back(32'h0);
        exp_bytes.push_back(8'h0F);
        exp_bytes.push_back(8'hAA);
        spi_cmd_addr(8'h03, 24'hFFFFFF);
        for (int i = 0; i < 2; i++) spi_byte(8'h00);
        spi_stop();

        // Deep power-down blocks reads until released
        spi_csb = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'hB9);
        spi_stop();
        check("pd_set", {31'h0, powered_down}, 32'h1);
        v0 = valid_seen;
        o0 = oe_seen;
        spi_cmd_addr(8'h03, 24'h000004);
        spi_byte(8'h00);
        spi_stop();
        check("pd_no_fetch", valid_seen - v0, 32'h0);
        check("pd_no_oe", oe_seen - o0, 32'h0);
        spi_csb = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'hAB);
        spi_stop();
        check("pd_released", {31'h0, powered_down}, 32'h0);
        exp_addrs.push_back(32'h8);
        exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'h66);
        spi_cmd_addr(8'h03, 24'h000008);
        for (int i = 0; i < 2; i++) spi_byte(8'h00);
        spi_stop();

        // Slow memory causes underrun; abort mid-byte, then a clean restart
        check("underrun_clear", {31'h0, underrun}, 32'h0);
        latency = 20;
        exp_addrs.push_back(32'h4);
        spi_cmd_addr(8'h03, 24'h000004);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        spi_stop();
        repeat (40) @(negedge clk);
        check("underrun_set", {31'h0, underrun}, 32'h1);
        latency = 0;
        exp_addrs.push_back(32'h0);
        exp_bytes.push_back(8'hAA);
        exp_bytes.push_back(8'hBB);
        spi_cmd_addr(8'h03, 24'h000000);
        for (int i = 0; i < 2; i++) spi_byte(8'h00);
        spi_stop();
        check("underrun_sticky", {31'h0, underrun}, 32'h1);

        // Asynchronous reset in the middle of a data byte
        exp_addrs.push_back(32'h8);
        exp_bytes.push_back(8'h55);
        spi_cmd_addr(8'h03, 24'h000008);
        spi_byte(8'h00);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        check("oe_before_reset", {31'h0, spi_miso_oe}, 32'h1);
        #2;
        resetn = 1'b0;
        spi_csb = 1'b1;
        #1;
        check("async_rst_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("async_rst_miso", {31'h0, spi_miso}, 32'h0);
        check("async_rst_underrun", {31'h0, underrun}, 32'h0);
        check("async_rst_rom_valid", {31'h0, rom_if.rom_valid}, 32'h0);
        check("async_rst_rom_addr", rom_if.rom_addr, 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        exp_addrs.push_back(32'h4);
        exp_bytes.push_back(8'h11);
        spi_cmd_addr(8'h03, 24'h000004);
        spi_byte(8'h00);
        spi_stop();
        check("post_reset_pd", {31'h0, powered_down}, 32'h0);

        repeat (30) @(negedge clk);
        check("bytes_drained", exp_bytes.size(), 32'h0);
        check("fetches_drained", exp_addrs.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
